// File: rtl/vertex_scheduler.sv
// Vertex issue sequencer: walks vertex memory for one frame, prefetches
// through a small skid FIFO and feeds the transformation stage over a
// valid/ready handshake. Camera parameters are frozen for the whole frame.
module vertex_scheduler #(
  parameter int VTX_AW     = 10,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              frame_start_in,
  input  logic [VTX_AW:0]   num_vtx_in,
  input  logic [31:0]       distance_in,
  input  logic [4:0]        pitch_in,
  output logic [VTX_AW-1:0] vtx_addr_out,
  input  logic [96:0]       vtx_data_in,
  output logic [127:0]      pos_out,
  output logic [31:0]       distance_out,
  output logic [4:0]        pitch_out,
  output logic              valid_out,
  output logic              obj_done_out,
  input  logic              ready_in,
  output logic              busy_out,
  output logic              frame_done_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] W_ONE = 32'h3f800000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q;
  logic [VTX_AW:0]   num_q;
  logic [VTX_AW:0]   read_ptr_q;
  logic [VTX_AW:0]   issued_q;
  logic [31:0]       distance_q;
  logic [4:0]        pitch_q;
  logic              frame_done_q;

  // One bit per outstanding BRAM read, plus a "last vertex of frame" tag
  // that travels alongside so the forced obj_done lines up with its data.
  logic [MEM_LAT-1:0] rd_vld_q;
  logic [MEM_LAT-1:0] rd_flast_q;

  logic [96:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic [CW-1:0]     inflight;
  logic              credit_ok;
  logic              issue;
  logic              issue_last;
  logic              push;
  logic              pop;
  logic              fifo_vld;
  logic [96:0]       head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Count reads still travelling through the BRAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + CW'(rd_vld_q[i]);
    end
  end

  // A read is only launched when a FIFO slot is guaranteed for its data,
  // so the FIFO can never overflow even with ready_in held low.
  assign credit_ok  = (32'(count_q) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign issue      = (state_q == S_RUN) && (read_ptr_q < num_q) && credit_ok;
  assign issue_last = (read_ptr_q == num_q - 1'b1);
  assign push       = rd_vld_q[MEM_LAT-1];
  assign fifo_vld   = (count_q != '0);
  assign pop        = fifo_vld && ready_in;
  assign head       = fifo_mem[rd_ptr_q];

  assign vtx_addr_out   = read_ptr_q[VTX_AW-1:0];
  assign valid_out      = fifo_vld;
  assign pos_out        = fifo_vld ? {head[95:0], W_ONE} : '0;
  assign obj_done_out   = fifo_vld & head[96];
  assign distance_out   = distance_q;
  assign pitch_out      = pitch_q;
  assign busy_out       = (state_q != S_IDLE);
  assign frame_done_out = frame_done_q;

  // Frame FSM, read pipeline, FIFO pointers and latched camera params.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      read_ptr_q   <= '0;
      issued_q     <= '0;
      distance_q   <= '0;
      pitch_q      <= '0;
      frame_done_q <= 1'b0;
      rd_vld_q     <= '0;
      rd_flast_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      frame_done_q  <= 1'b0;

      rd_vld_q[0]   <= issue;
      rd_flast_q[0] <= issue_last;
      for (int i = 1; i < MEM_LAT; i++) begin
        rd_vld_q[i]   <= rd_vld_q[i-1];
        rd_flast_q[i] <= rd_flast_q[i-1];
      end

      if (issue) read_ptr_q <= read_ptr_q + 1'b1;
      if (push)  wr_ptr_q   <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        issued_q <= issued_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase

      case (state_q)
        S_IDLE: begin
          if (frame_start_in) begin
            num_q      <= num_vtx_in;
            distance_q <= distance_in;
            pitch_q    <= pitch_in;
            read_ptr_q <= '0;
            issued_q   <= '0;
            state_q    <= (num_vtx_in == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issued_q == num_q) state_q <= S_DONE;
        end
        S_DONE: begin
          frame_done_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; the frame's final vertex always closes its object.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {vtx_data_in[96] | rd_flast_q[MEM_LAT-1], vtx_data_in[95:0]};
    end
  end

endmodule
